lzc_norm_pipe: RTL and testbench
================================

LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, meaning data width in bits, legal range 2..64.
REQ-002 The block SHALL have the parameter TAG_WIDTH, default 4, meaning the width of the user tag carried alongside the data.
REQ-003 The block SHALL have the parameter CNT_WIDTH, default $clog2(WIDTH+1), derived and not overridden by users.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous pipeline clear.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: input beat accepted when high with in_valid_i.
REQ-009 The block SHALL have port in_data_i, input, WIDTH bits: operand.
REQ-010 The block SHALL have port in_mode_i, input, 1 bit: per-beat mode; 0 = trailing-zero count, 1 = leading-zero count.
REQ-011 The block SHALL have port in_tag_i, input, TAG_WIDTH bits: user tag.
REQ-012 The block SHALL have port out_valid_o, output, 1 bit: result valid.
REQ-013 The block SHALL have port out_ready_i, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port out_cnt_o, output, CNT_WIDTH bits: zero count.
REQ-015 The block SHALL have port out_empty_o, output, 1 bit: the operand was all zeros.
REQ-016 The block SHALL have port out_norm_o, output, WIDTH bits: normalized operand.
REQ-017 The block SHALL have port out_tag_o, output, TAG_WIDTH bits: tag of the beat.
REQ-018 The block SHALL have port stat_empty_o, output, 32 bits: count of all-zero beats accepted.

Function
REQ-019 The block SHALL be a two-stage pipeline: S1 registers the operand, mode, tag and count; S2 registers the normalized result, count, empty flag and tag.
REQ-020 The block SHALL present a result on out_* exactly 2 cycles after input acceptance when there is no backpressure, sustaining 1 beat per cycle.
REQ-021 In leading mode, the count SHALL be the number of zeros above the highest set bit, and out_norm_o SHALL be in_data_i shifted left by the count.
REQ-022 In trailing mode, the count SHALL be the number of zeros below the lowest set bit, and out_norm_o SHALL be in_data_i shifted right by the count.
REQ-023 For an all-zero operand, the block SHALL set out_cnt_o = WIDTH, out_empty_o = 1 and out_norm_o = 0, in either mode.
REQ-024 Stage advance SHALL be s2_adv = !s2_valid | out_ready_i, s1_adv = !s1_valid | s2_adv, and in_ready_o = s1_adv (a combinational ready path is permitted).
REQ-025 Stalled stages SHALL hold data, tag and valid unchanged, and out_* SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-026 flush_i SHALL clear both stage valids on the next edge and SHALL take priority over acceptance; in_ready_o SHALL be 0 while flush_i=1.
REQ-027 Beats SHALL leave in acceptance order, with none dropped or duplicated outside flush/reset.
REQ-028 stat_empty_o SHALL increment on each accepted all-zero beat, saturate at 2^32-1, and be unaffected by flush_i.

Reset
REQ-029 While rst_i=1, s1_valid, s2_valid, out_valid_o and stat_empty_o SHALL be 0, and out_cnt_o, out_norm_o, out_tag_o and out_empty_o SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats, and out_valid_o SHALL fall asynchronously.

Configuration
REQ-031 When LZC_NORM_STATS_EN is defined, the stat_empty_o counter SHALL be implemented as in REQ-028.
REQ-032 When LZC_NORM_STATS_EN is undefined, stat_empty_o SHALL be tied to 0 with no counter logic, and the port SHALL remain present.

Structure
REQ-033 The package lzc_norm_pkg SHALL hold the mode enum (LZC_TRAILING=1'b0, LZC_LEADING=1'b1) and a cnt_width(width) function returning $clog2(width+1).
REQ-034 The combinational counter SHALL be a sub-module named lzc_tree (parameter WIDTH, ports in/mode/cnt/empty, empty count = WIDTH), instantiated once in S1.

Verification
REQ-035 With WIDTH=8, in=0001_0110 in leading mode, the bench SHALL check cnt=3, norm=1011_0000 and empty=0, appearing 2 cycles after acceptance.
REQ-036 With WIDTH=8, in=0001_0110 in trailing mode, the bench SHALL check cnt=1 and norm=0000_1011; with in=1000_0000 in leading mode, cnt=0 and norm unchanged.
REQ-037 With in=0 in both modes, the bench SHALL check cnt=8, empty=1, norm=0, and that stat_empty_o increments by 2 (when LZC_NORM_STATS_EN is defined).
REQ-038 Driving 4 back-to-back beats with tags 1..4 while out_ready_i=0 for 5 cycles, the bench SHALL check that in_ready_o drops after 2 accepts and that outputs appear in tag order 1..4 with none lost.
REQ-039 Asserting flush_i with both stages full, the bench SHALL check out_valid_o=0 on the next cycle and that a beat accepted afterwards emerges normally.
REQ-040 Asserting rst_i mid-stream for 1 cycle, the bench SHALL check that all outputs go to 0 immediately and that no pre-reset tag appears afterward.

Source files
------------

// File: rtl/lzc_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzc_norm_pkg
// Purpose  : Shared mode encoding and count-width helper for the LZC/normalize
//            pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package lzc_norm_pkg;

    typedef enum logic {
        LZC_TRAILING = 1'b0,
        LZC_LEADING  = 1'b1
    } lzc_mode_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : lzc_norm_pkg
`default_nettype wire

// File: rtl/lzc_tree.sv
`default_nettype none
// ============================================================================
// Module   : lzc_tree
// Purpose  : Combinational leading/trailing zero counter; all-zero input
//            reports a count of WIDTH with empty_o set.
// Revision : 1.0 - initial release
// ============================================================================
module lzc_tree
    import lzc_norm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = cnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    input  logic                 mode_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    logic [WIDTH-1:0] w_src;

    // Trailing mode reverses the operand so one leading-zero scan serves both.
    always_comb begin
        w_src   = '0;
        cnt_o   = CNT_WIDTH'(WIDTH);
        empty_o = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_src[i] = (lzc_mode_e'(mode_i) == LZC_LEADING) ? in_i[i] : in_i[WIDTH-1-i];
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (empty_o && w_src[i]) begin
                cnt_o   = CNT_WIDTH'(WIDTH - 1 - i);
                empty_o = 1'b0;
            end
        end
    end

endmodule : lzc_tree
`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzc_norm_pipe
// Purpose  : Two-stage valid/ready pipeline counting leading or trailing zeros
//            and normalizing the operand. Define LZC_NORM_STATS_EN to enable
//            the all-zero beat counter on stat_empty_o.
// Revision : 1.0 - initial release
// ============================================================================
module lzc_norm_pipe
    import lzc_norm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4,
    parameter int CNT_WIDTH = cnt_width(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic                 in_mode_i,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CNT_WIDTH-1:0] out_cnt_o,
    output logic                 out_empty_o,
    output logic [WIDTH-1:0]     out_norm_o,
    output logic [TAG_WIDTH-1:0] out_tag_o,
    output logic [31:0]          stat_empty_o
);

    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_empty;
    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_norm;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_data;
    lzc_mode_e            r_s1_mode;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic [CNT_WIDTH-1:0] r_s1_cnt;
    logic                 r_s1_empty;

    logic                 r_s2_valid;
    logic [WIDTH-1:0]     r_s2_norm;
    logic [CNT_WIDTH-1:0] r_s2_cnt;
    logic                 r_s2_empty;
    logic [TAG_WIDTH-1:0] r_s2_tag;

    lzc_tree #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lzc_tree (
        .in_i    (in_data_i),
        .mode_i  (in_mode_i),
        .cnt_o   (w_cnt),
        .empty_o (w_empty)
    );

    assign w_s2_adv   = !r_s2_valid || out_ready_i;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign in_ready_o = w_s1_adv && !flush_i;
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= LZC_TRAILING;
            r_s1_tag   <= '0;
            r_s1_cnt   <= '0;
            r_s1_empty <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= in_valid_i;
            end
            if (w_accept) begin
                r_s1_data  <= in_data_i;
                r_s1_mode  <= lzc_mode_e'(in_mode_i);
                r_s1_tag   <= in_tag_i;
                r_s1_cnt   <= w_cnt;
                r_s1_empty <= w_empty;
            end
        end
    end

    // An all-zero operand shifts to zero regardless of direction or count.
    always_comb begin
        w_norm = '0;
        if (r_s1_mode == LZC_LEADING) begin
            w_norm = r_s1_data << r_s1_cnt;
        end else begin
            w_norm = r_s1_data >> r_s1_cnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_valid <= 1'b0;
            r_s2_norm  <= '0;
            r_s2_cnt   <= '0;
            r_s2_empty <= 1'b0;
            r_s2_tag   <= '0;
        end else begin
            if (flush_i) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (!flush_i && w_s2_adv && r_s1_valid) begin
                r_s2_norm  <= w_norm;
                r_s2_cnt   <= r_s1_cnt;
                r_s2_empty <= r_s1_empty;
                r_s2_tag   <= r_s1_tag;
            end
        end
    end

    assign out_valid_o = r_s2_valid;
    assign out_norm_o  = r_s2_norm;
    assign out_cnt_o   = r_s2_cnt;
    assign out_empty_o = r_s2_empty;
    assign out_tag_o   = r_s2_tag;

`ifdef LZC_NORM_STATS_EN
    logic [31:0] r_stat_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_empty <= 32'd0;
        end else if (w_accept && w_empty && (r_stat_empty != 32'hFFFF_FFFF)) begin
            r_stat_empty <= r_stat_empty + 32'd1;
        end
    end

    assign stat_empty_o = r_stat_empty;
`else
    assign stat_empty_o = 32'd0;
`endif

endmodule : lzc_norm_pipe
`default_nettype wire

// File: tb/tb_lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzc_norm_pipe
// Purpose  : Self-checking bench for lzc_norm_pipe (WIDTH=8) with a queue
//            scoreboard of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzc_norm_pipe;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_cnt;
    logic          out_empty;
    logic [W-1:0]  out_norm;
    logic [TW-1:0] out_tag;
    logic [31:0]   stat_empty;

    lzc_norm_pipe #(
        .WIDTH     (W),
        .TAG_WIDTH (TW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_mode_i    (in_mode),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_cnt_o    (out_cnt),
        .out_empty_o  (out_empty),
        .out_norm_o   (out_norm),
        .out_tag_o    (out_tag),
        .stat_empty_o (stat_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          empty;
        logic [W-1:0]  norm;
        logic [TW-1:0] tag;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    exp_t ce;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic [31:0] stat0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Output monitor: every completed transfer pops and checks one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                ce = sb.pop_front();
                chk("out_tag",   64'(out_tag),   64'(ce.tag));
                chk("out_cnt",   64'(out_cnt),   64'(ce.cnt));
                chk("out_norm",  64'(out_norm),  64'(ce.norm));
                chk("out_empty", 64'(out_empty), 64'(ce.empty));
                if (ce.lat) chk("latency", 64'(cyc), 64'(ce.acc + 2));
            end
        end
    end

    function automatic void model(input logic [W-1:0] d, input logic m,
                                  output logic [CW-1:0] c, output logic [W-1:0] n,
                                  output logic e);
        c = '0;
        n = '0;
        e = (d == '0);
        if (e) begin
            c = CW'(W);
        end else if (m) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (d[i]) break;
                c = c + 1'b1;
            end
            n = d << c;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (d[i]) break;
                c = c + 1'b1;
            end
            n = d >> c;
        end
    endfunction

    task automatic send(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t,
                        input logic [CW-1:0] ec, input logic [W-1:0] en,
                        input logic ee, input bit lat);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        e.cnt   = ec;
        e.norm  = en;
        e.empty = ee;
        e.tag   = t;
        e.acc   = cyc;
        e.lat   = lat;
        @(posedge clk);
        if (n < 50) sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] d, input logic m, input logic [TW-1:0] t,
                          input bit lat);
        logic [CW-1:0] c;
        logic [W-1:0]  nv;
        logic          e;
        model(d, m, c, nv, e);
        send(d, m, t, c, nv, e, lat);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid),  64'd0);
        chk("rst_out_cnt",   64'(out_cnt),    64'd0);
        chk("rst_out_norm",  64'(out_norm),   64'd0);
        chk("rst_out_tag",   64'(out_tag),    64'd0);
        chk("rst_out_empty", 64'(out_empty),  64'd0);
        chk("rst_stat",      64'(stat_empty), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // Directed values with fixed expectations
        send(8'b0001_0110, 1'b1, 4'd1, 4'd3, 8'b1011_0000, 1'b0, 1'b1);
        send(8'b0001_0110, 1'b0, 4'd2, 4'd1, 8'b0000_1011, 1'b0, 1'b1);
        send(8'b1000_0000, 1'b1, 4'd3, 4'd0, 8'b1000_0000, 1'b0, 1'b1);
        send(8'b0000_0001, 1'b0, 4'd4, 4'd0, 8'b0000_0001, 1'b0, 1'b1);
        send(8'b0000_0001, 1'b1, 4'd5, 4'd7, 8'b1000_0000, 1'b0, 1'b1);
        drain();

        // All-zero operands in both modes
        stat0 = stat_empty;
        send(8'h00, 1'b1, 4'd6, 4'd8, 8'h00, 1'b1, 1'b1);
        send(8'h00, 1'b0, 4'd7, 4'd8, 8'h00, 1'b1, 1'b1);
        drain();
`ifdef LZC_NORM_STATS_EN
        chk("stat_incr", 64'(stat_empty - stat0), 64'd2);
`else
        chk("stat_tied", 64'(stat_empty), 64'd0);
`endif

        // Random back-to-back traffic
        for (int k = 0; k < 24; k++) begin
            send_m(W'($urandom) >> $urandom_range(0, 8), 1'($urandom), TW'(k), 1'b1);
        end
        drain();

        // Backpressure: tags 1..4 with downstream stalled
        out_ready = 1'b0;
        send_m(8'h35, 1'b1, 4'd1, 1'b0);
        send_m(8'h48, 1'b0, 4'd2, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h0C;
        in_mode  = 1'b1;
        in_tag   = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_tag",   64'(out_tag),   64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send_m(8'h0C, 1'b1, 4'd3, 1'b0);
        send_m(8'h90, 1'b0, 4'd4, 1'b0);
        drain();

        // Flush with both stages full; flush beats acceptance
        out_ready = 1'b0;
        send_m(8'h21, 1'b1, 4'd7, 1'b0);
        send_m(8'h42, 1'b0, 4'd8, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_tag   = 4'd15;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send_m(8'h0A, 1'b1, 4'd11, 1'b1);
        drain();

        // Mid-stream reset
        out_ready = 1'b0;
        send_m(8'h00, 1'b1, 4'd9,  1'b0);
        send_m(8'h06, 1'b0, 4'd10, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_out_valid", 64'(out_valid),  64'd0);
        chk("mrst_out_cnt",   64'(out_cnt),    64'd0);
        chk("mrst_out_norm",  64'(out_norm),   64'd0);
        chk("mrst_out_tag",   64'(out_tag),    64'd0);
        chk("mrst_out_empty", 64'(out_empty),  64'd0);
        chk("mrst_stat",      64'(stat_empty), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send_m(8'h30, 1'b1, 4'd5, 1'b1);
        send_m(8'h30, 1'b0, 4'd6, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("final_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_lzc_norm_pipe
`default_nettype wire
